// File: rtl/reg_trace_rules.sv
// reg_trace_rules
//   Match-rule register bank for the trace trigger. Rules are edited through a
//   staging window (pattern + mask) and copied into the selected rule in one
//   edge, so the trigger never sees a half-written pattern/mask pair.
//   Optional per-rule saturating hit counters are read through a snapshot so a
//   multi-byte readout cannot tear.
//
//   Optional feature macro: TRACE_HIT_COUNTERS_EN
//     defined   : hit counters, snapshot, HIT_COUNT and CLEAR_COUNTS present
//     undefined : no counter logic, HIT_COUNT reads 0, INFO byte2 reads 0
//
//   Ports
//     usb_clk               sole clock
//     reset_n               asynchronous active-low reset
//     reg_address[7:0]      [7:6] block select, [5:0] register offset
//     reg_bytecnt           byte index inside the addressed register
//     write_data[7:0]       write byte
//     read_data[7:0]        registered read byte (valid cycle after reg_read)
//     reg_read / reg_write  access strobes
//     reg_addrvalid         address qualifier
//     selected              this block is addressed
//     I_match_hit           per-rule one-cycle hit pulses
//     O_trace_patterns      rule r at [r*pBUFFER_SIZE +: pBUFFER_SIZE]
//     O_trace_masks         same packing as patterns
//     O_pattern_enable      per-rule match enable
//     O_pattern_trig_enable per-rule trigger enable
//     O_commit              one-cycle pulse, coincident with new rule values
module reg_trace_rules #(
  parameter int         pBYTECNT_SIZE = 7,
  parameter int         pBUFFER_SIZE  = 64,
  parameter int         pMATCH_RULES  = 8,
  parameter logic [1:0] pSELECT       = 2'b11,
  parameter int         pCOUNT_WIDTH  = 16
) (
  input  logic                                   usb_clk,
  input  logic                                   reset_n,
  input  logic [7:0]                             reg_address,
  input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  input  logic [7:0]                             write_data,
  output logic [7:0]                             read_data,
  input  logic                                   reg_read,
  input  logic                                   reg_write,
  input  logic                                   reg_addrvalid,
  output logic                                   selected,
  input  logic [pMATCH_RULES-1:0]                I_match_hit,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_patterns,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_masks,
  output logic [pMATCH_RULES-1:0]                O_pattern_enable,
  output logic [pMATCH_RULES-1:0]                O_pattern_trig_enable,
  output logic                                   O_commit
);

  localparam int NBYTES = pBUFFER_SIZE / 8;

  localparam logic [5:0] OFF_INFO   = 6'h00;
  localparam logic [5:0] OFF_INDEX  = 6'h01;
  localparam logic [5:0] OFF_SPAT   = 6'h02;
  localparam logic [5:0] OFF_SMSK   = 6'h03;
  localparam logic [5:0] OFF_COMMIT = 6'h04;
  localparam logic [5:0] OFF_LOAD   = 6'h05;
  localparam logic [5:0] OFF_PEN    = 6'h06;
  localparam logic [5:0] OFF_TEN    = 6'h07;
  localparam logic [5:0] OFF_HIT    = 6'h08;
  localparam logic [5:0] OFF_CLEAR  = 6'h09;

`ifdef TRACE_HIT_COUNTERS_EN
  localparam logic [7:0] INFO_COUNT = 8'(pCOUNT_WIDTH);
`else
  localparam logic [7:0] INFO_COUNT = 8'h00;
`endif

  logic [5:0]              offset;
  int                      bytecnt;
  logic                    wr;
  logic                    rd;

  logic [3:0]              rule_index;
  logic                    err;
  logic [pMATCH_RULES-1:0] pat_en;
  logic [pMATCH_RULES-1:0] trig_en;
  logic [15:0]             pen_pad;
  logic [15:0]             ten_pad;

  logic [pBUFFER_SIZE-1:0] stage_pattern;
  logic [pBUFFER_SIZE-1:0] stage_mask;
  logic [pBUFFER_SIZE-1:0] rule_pattern [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0] rule_mask    [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0] load_pattern;
  logic [pBUFFER_SIZE-1:0] load_mask;

  logic                    idx_valid;
  logic                    commit_req;
  logic [7:0]              hit_byte;
  logic [7:0]              rd_mux;

  assign selected   = reg_addrvalid && (reg_address[7:6] == pSELECT);
  assign offset     = reg_address[5:0];
  assign bytecnt    = int'(reg_bytecnt);
  assign wr         = selected && reg_write;
  assign rd         = selected && reg_read;
  assign idx_valid  = ({1'b0, rule_index} < 5'(pMATCH_RULES));
  // 0x80 to RULE_COMMIT only clears the error flag; every other value commits.
  assign commit_req = wr && (offset == OFF_COMMIT) && (write_data != 8'h80);
  assign pen_pad    = 16'(pat_en);
  assign ten_pad    = 16'(trig_en);

  // Byte-addressed write into an enable vector; bits past the rule count are dropped.
  function automatic logic [pMATCH_RULES-1:0] en_write(
    input logic [pMATCH_RULES-1:0] cur,
    input logic [7:0]              data,
    input int                      bc
  );
    logic [pMATCH_RULES-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < pMATCH_RULES; i++) begin
      if ((i / 8) == bc) nxt[i] = data[3'(i % 8)];
    end
    return nxt;
  endfunction

  // Rule selected by RULE_INDEX; out-of-range index yields the reset image.
  always_comb begin
    load_pattern = '0;
    load_mask    = '1;
    for (int r = 0; r < pMATCH_RULES; r++) begin
      if (rule_index == 4'(r)) begin
        load_pattern = rule_pattern[r];
        load_mask    = rule_mask[r];
      end
    end
  end

  // Staging window
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_pattern <= '0;
      stage_mask    <= '1;
    end else if (wr && (offset == OFF_LOAD)) begin
      stage_pattern <= load_pattern;
      stage_mask    <= load_mask;
    end else if (wr) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bytecnt == b) begin
          if (offset == OFF_SPAT) stage_pattern[8*b +: 8] <= write_data;
          if (offset == OFF_SMSK) stage_mask[8*b +: 8]    <= write_data;
        end
      end
    end
  end

  // Committed rules
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < pMATCH_RULES; r++) begin
        rule_pattern[r] <= '0;
        rule_mask[r]    <= '1;
      end
    end else if (commit_req && idx_valid) begin
      for (int r = 0; r < pMATCH_RULES; r++) begin
        if (rule_index == 4'(r)) begin
          rule_pattern[r] <= stage_pattern;
          rule_mask[r]    <= stage_mask;
        end
      end
    end
  end

  // Index, error flag, enables, commit pulse
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      rule_index <= 4'h0;
      err        <= 1'b0;
      pat_en     <= '0;
      trig_en    <= '0;
      O_commit   <= 1'b0;
    end else begin
      O_commit <= commit_req && idx_valid;
      if (wr && (offset == OFF_INDEX)) rule_index <= write_data[3:0];
      if (wr && (offset == OFF_COMMIT)) begin
        if (write_data == 8'h80) err <= 1'b0;
        else if (!idx_valid)     err <= 1'b1;
      end
      if (wr && (offset == OFF_PEN)) pat_en  <= en_write(pat_en, write_data, bytecnt);
      if (wr && (offset == OFF_TEN)) trig_en <= en_write(trig_en, write_data, bytecnt);
    end
  end

`ifdef TRACE_HIT_COUNTERS_EN
  localparam int CBYTES = pCOUNT_WIDTH / 8;

  logic [pCOUNT_WIDTH-1:0] hit_count [pMATCH_RULES];
  logic [pCOUNT_WIDTH-1:0] snapshot;
  logic [pCOUNT_WIDTH-1:0] count_sel;
  logic                    clear_req;

  assign clear_req = wr && (offset == OFF_CLEAR);

  always_comb begin
    count_sel = '0;
    for (int r = 0; r < pMATCH_RULES; r++) begin
      if (rule_index == 4'(r)) count_sel = hit_count[r];
    end
  end

  // Clear has priority over a coincident hit.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < pMATCH_RULES; r++) hit_count[r] <= '0;
    end else begin
      for (int r = 0; r < pMATCH_RULES; r++) begin
        if (clear_req)
          hit_count[r] <= '0;
        else if (I_match_hit[r] && (hit_count[r] != '1))
          hit_count[r] <= hit_count[r] + 1'b1;
      end
    end
  end

  // Byte 0 read freezes the whole counter so the upper bytes match it.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n)
      snapshot <= '0;
    else if (rd && (offset == OFF_HIT) && (bytecnt == 0))
      snapshot <= count_sel;
  end

  always_comb begin
    hit_byte = 8'h00;
    if (bytecnt == 0) hit_byte = count_sel[7:0];
    for (int b = 1; b < CBYTES; b++) begin
      if (bytecnt == b) hit_byte = snapshot[8*b +: 8];
    end
  end
`else
  logic unused_hits;
  assign unused_hits = ^I_match_hit;
  assign hit_byte    = 8'h00;
`endif

  // Read mux
  always_comb begin
    rd_mux = 8'h00;
    case (offset)
      OFF_INFO: begin
        if (bytecnt == 0)      rd_mux = 8'(pMATCH_RULES);
        else if (bytecnt == 1) rd_mux = 8'(NBYTES);
        else if (bytecnt == 2) rd_mux = INFO_COUNT;
      end
      OFF_INDEX:  if (bytecnt == 0) rd_mux = {4'h0, rule_index};
      OFF_SPAT: begin
        for (int b = 0; b < NBYTES; b++)
          if (bytecnt == b) rd_mux = stage_pattern[8*b +: 8];
      end
      OFF_SMSK: begin
        for (int b = 0; b < NBYTES; b++)
          if (bytecnt == b) rd_mux = stage_mask[8*b +: 8];
      end
      OFF_COMMIT: if (bytecnt == 0) rd_mux = {7'h00, err};
      OFF_PEN: begin
        if (bytecnt == 0)      rd_mux = pen_pad[7:0];
        else if (bytecnt == 1) rd_mux = pen_pad[15:8];
      end
      OFF_TEN: begin
        if (bytecnt == 0)      rd_mux = ten_pad[7:0];
        else if (bytecnt == 1) rd_mux = ten_pad[15:8];
      end
      OFF_HIT:    rd_mux = hit_byte;
      default:    rd_mux = 8'h00;
    endcase
  end

  // Registered read data
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n)  read_data <= 8'h00;
    else if (rd)   read_data <= rd_mux;
  end

  for (genvar r = 0; r < pMATCH_RULES; r++) begin : g_out
    assign O_trace_patterns[r*pBUFFER_SIZE +: pBUFFER_SIZE] = rule_pattern[r];
    assign O_trace_masks[r*pBUFFER_SIZE +: pBUFFER_SIZE]    = rule_mask[r];
  end

  assign O_pattern_enable      = pat_en;
  assign O_pattern_trig_enable = trig_en;

endmodule

// File: tb/tb_reg_trace_rules.sv
module tb_reg_trace_rules;

  localparam int NR   = 8;
  localparam int BW   = 64;
  localparam int NB   = BW / 8;
  localparam int CW   = 16;
  localparam int MAXC = (1 << CW) - 1;
`ifdef TRACE_HIT_COUNTERS_EN
  localparam bit         CNT_EN = 1'b1;
  localparam logic [7:0] INFO2  = 8'h10;
`else
  localparam bit         CNT_EN = 1'b0;
  localparam logic [7:0] INFO2  = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    reg_address;
  logic [6:0]    reg_bytecnt;
  logic [7:0]    write_data;
  logic [7:0]    read_data;
  logic          reg_read;
  logic          reg_write;
  logic          reg_addrvalid;
  logic          selected;
  logic [NR-1:0] I_match_hit;
  logic [NR*BW-1:0] O_trace_patterns;
  logic [NR*BW-1:0] O_trace_masks;
  logic [NR-1:0] O_pattern_enable;
  logic [NR-1:0] O_pattern_trig_enable;
  logic          O_commit;

  reg_trace_rules dut (
    .usb_clk              (clk),
    .reset_n              (reset_n),
    .reg_address          (reg_address),
    .reg_bytecnt          (reg_bytecnt),
    .write_data           (write_data),
    .read_data            (read_data),
    .reg_read             (reg_read),
    .reg_write            (reg_write),
    .reg_addrvalid        (reg_addrvalid),
    .selected             (selected),
    .I_match_hit          (I_match_hit),
    .O_trace_patterns     (O_trace_patterns),
    .O_trace_masks        (O_trace_masks),
    .O_pattern_enable     (O_pattern_enable),
    .O_pattern_trig_enable(O_pattern_trig_enable),
    .O_commit             (O_commit)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [BW-1:0] m_pat [NR];
  logic [BW-1:0] m_msk [NR];
  logic [BW-1:0] m_sp, m_sm;
  logic [3:0]    m_idx;
  logic          m_err;
  logic [15:0]   m_pen, m_ten;
  int            m_cnt [NR];
  int            m_snap;
  logic          m_commit;

  int            n_chk  = 0;
  int            n_pass = 0;
  bit            cmp_on = 0;
  bit            rd_chk = 0;
  logic [7:0]    exp_rd = 8'h00;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_pat[r] = '0;
      m_msk[r] = '1;
      m_cnt[r] = 0;
    end
    m_sp = '0; m_sm = '1; m_idx = 4'h0; m_err = 1'b0;
    m_pen = 16'h0; m_ten = 16'h0; m_snap = 0; m_commit = 1'b0;
  endtask

  function automatic logic [511:0] pack(input bit masks);
    logic [511:0] p;
    p = '0;
    for (int r = 0; r < NR; r++) p[r*BW +: BW] = masks ? m_msk[r] : m_pat[r];
    return p;
  endfunction

  function automatic logic [7:0] model_read(input int off, input int bc);
    logic [7:0] v;
    v = 8'h00;
    case (off)
      0: if (bc == 0) v = 8'(NR); else if (bc == 1) v = 8'(NB); else if (bc == 2) v = CNT_EN ? 8'(CW) : 8'h00;
      1: if (bc == 0) v = {4'h0, m_idx};
      2: if (bc < NB) v = 8'(m_sp >> (8*bc));
      3: if (bc < NB) v = 8'(m_sm >> (8*bc));
      4: if (bc == 0) v = {7'h00, m_err};
      6: if (bc < 2) v = 8'(m_pen >> (8*bc));
      7: if (bc < 2) v = 8'(m_ten >> (8*bc));
      8: if (CNT_EN) begin
           if (bc == 0) v = (int'(m_idx) < NR) ? 8'(m_cnt[int'(m_idx)]) : 8'h00;
           else if (bc < CW/8) v = 8'(m_snap >> (8*bc));
         end
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // State after one clock edge, from the pre-edge state and the access seen.
  task automatic model_step(input bit w, input bit r, input int off, input int bc,
                            input logic [7:0] d, input logic [NR-1:0] hits);
    bit clr;
    logic [15:0] vmask, keep, nv;
    clr = 0;
    m_commit = 1'b0;
    vmask = 16'((1 << NR) - 1);
    if (CNT_EN && r && off == 8 && bc == 0)
      m_snap = (int'(m_idx) < NR) ? m_cnt[int'(m_idx)] : 0;
    if (w) begin
      case (off)
        1: m_idx = d[3:0];
        2: if (bc < NB) m_sp[8*bc +: 8] = d;
        3: if (bc < NB) m_sm[8*bc +: 8] = d;
        4: begin
             if (d == 8'h80) m_err = 1'b0;
             else if (int'(m_idx) < NR) begin
               m_pat[int'(m_idx)] = m_sp;
               m_msk[int'(m_idx)] = m_sm;
               m_commit = 1'b1;
             end else m_err = 1'b1;
           end
        5: begin
             if (int'(m_idx) < NR) begin m_sp = m_pat[int'(m_idx)]; m_sm = m_msk[int'(m_idx)]; end
             else begin m_sp = '0; m_sm = '1; end
           end
        6, 7: if (bc < 2) begin
             keep = ~(16'h00FF << (8*bc));
             nv   = (16'(d) << (8*bc)) & vmask;
             if (off == 6) m_pen = (m_pen & keep) | nv;
             else          m_ten = (m_ten & keep) | nv;
           end
        9: if (CNT_EN) clr = 1;
        default: ;
      endcase
    end
    if (CNT_EN) begin
      for (int k = 0; k < NR; k++) begin
        if (clr) m_cnt[k] = 0;
        else if (hits[k] && m_cnt[k] < MAXC) m_cnt[k]++;
      end
    end
  endtask

  // One bus cycle: drive after negedge, let the edge happen, advance model.
  task automatic cyc(input bit sel, input bit w, input bit r, input int off, input int bc,
                     input logic [7:0] d, input logic [NR-1:0] hits);
    logic [7:0] er;
    reg_addrvalid = w | r;
    reg_address   = {sel ? 2'b11 : 2'($urandom_range(0, 2)), 6'(off)};
    reg_bytecnt   = 7'(bc);
    write_data    = d;
    reg_write     = w;
    reg_read      = r;
    I_match_hit   = hits;
    er = model_read(off, bc);
    @(posedge clk);
    model_step(sel && w, sel && r, off, bc, d, hits);
    if (sel && r) begin exp_rd = er; rd_chk = 1; end
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int off, input int bc, input logic [7:0] d);
    cyc(1, 1, 0, off, bc, d, '0);
  endtask

  task automatic idle(input logic [NR-1:0] hits);
    cyc(1, 0, 0, 0, 0, 8'h00, hits);
  endtask

  task automatic rd_lit(input string nm, input int off, input int bc, input logic [7:0] lit);
    cyc(1, 0, 1, off, bc, 8'h00, '0);
    chk(nm, 512'(read_data), 512'(lit));
    chk({nm, "_model"}, 512'(exp_rd), 512'(lit));
  endtask

  // Compare process: registered outputs checked on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("patterns", O_trace_patterns, pack(0));
        chk("masks", O_trace_masks, pack(1));
        chk("pattern_enable", 512'(O_pattern_enable), 512'(m_pen));
        chk("trig_enable", 512'(O_pattern_trig_enable), 512'(m_ten));
        chk("commit", 512'(O_commit), 512'(m_commit));
        chk("selected", 512'(selected), 512'(reg_addrvalid && reg_address[7:6] == 2'b11));
        if (rd_chk) begin
          chk("read_data", 512'(read_data), 512'(exp_rd));
          rd_chk = 0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] pat_lit;
  logic [63:0] msk_lit;

  initial begin
    reset_n = 1'b0;
    reg_address = 8'h00; reg_bytecnt = '0; write_data = 8'h00;
    reg_read = 0; reg_write = 0; reg_addrvalid = 0; I_match_hit = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    cmp_on = 1;

    // Reset state
    chk("rst_masks", 512'(O_trace_masks), {512{1'b1}});
    chk("rst_patterns", 512'(O_trace_patterns), 512'(0));
    chk("rst_read_data", 512'(read_data), 512'(0));
    chk("rst_commit", 512'(O_commit), 512'(0));
    rd_lit("info0", 0, 0, 8'h08);
    rd_lit("info1", 0, 1, 8'h08);
    rd_lit("info2", 0, 2, INFO2);
    rd_lit("pen_rst", 6, 0, 8'h00);
    rd_lit("smask_rst", 3, 5, 8'hFF);

    // Commit to rule 3
    pat_lit = 64'h1122334455667788;
    msk_lit = 64'hFF00FF00FF00FF00;
    wr(1, 0, 8'h03);
    for (int b = 0; b < NB; b++) wr(2, b, pat_lit[8*b +: 8]);
    for (int b = 0; b < NB; b++) wr(3, b, msk_lit[8*b +: 8]);
    wr(4, 0, 8'h01);
    chk("commit_pulse", 512'(O_commit), 512'(1));
    chk("rule3_pat", 512'(O_trace_patterns[3*BW +: BW]), 512'(64'h1122334455667788));
    chk("rule3_msk", 512'(O_trace_masks[3*BW +: BW]), 512'(64'hFF00FF00FF00FF00));
    chk("rule2_pat", 512'(O_trace_patterns[2*BW +: BW]), 512'(0));
    idle('0);
    chk("commit_one_cycle", 512'(O_commit), 512'(0));
    wr(2, 9, 8'h5A);
    rd_lit("stage_oob", 2, 9, 8'h00);

    // Out-of-range commit
    wr(1, 0, 8'h09);
    wr(4, 0, 8'h01);
    chk("bad_commit_pulse", 512'(O_commit), 512'(0));
    rd_lit("err_set", 4, 0, 8'h01);
    wr(4, 0, 8'h80);
    rd_lit("err_clr", 4, 0, 8'h00);
    wr(5, 0, 8'h00);
    rd_lit("load_oob_mask", 3, 0, 8'hFF);

    // Enables: bits past the rule count dropped
    wr(6, 1, 8'hFF);
    rd_lit("pen_hi", 6, 1, 8'h00);
    wr(7, 0, 8'hA5);
    rd_lit("ten_lo", 7, 0, 8'hA5);

    // Counters
    wr(1, 0, 8'h02);
`ifdef TRACE_HIT_COUNTERS_EN
    wr(9, 0, 8'h00);
    for (int i = 0; i < 70000; i++) idle(8'h04);
    rd_lit("hit_sat0", 8, 0, 8'hFF);
    rd_lit("hit_sat1", 8, 1, 8'hFF);
    cyc(1, 1, 0, 9, 0, 8'h00, 8'h04);
    rd_lit("hit_clr0", 8, 0, 8'h00);
    rd_lit("hit_clr1", 8, 1, 8'h00);
    for (int i = 0; i < 255; i++) idle(8'h04);
    rd_lit("snap0", 8, 0, 8'hFF);
    idle(8'h04);
    rd_lit("snap1", 8, 1, 8'h00);
`else
    for (int i = 0; i < 20; i++) idle(8'h04);
    rd_lit("hit_off0", 8, 0, 8'h00);
    rd_lit("hit_off1", 8, 1, 8'h00);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int k, off, bc;
      bit sel, w, r;
      logic [7:0] d;
      logic [NR-1:0] hits;
      k    = $urandom_range(0, 99);
      off  = $urandom_range(0, 11);
      bc   = $urandom_range(0, 9);
      d    = 8'($urandom);
      hits = ($urandom_range(0, 1) == 1) ? NR'($urandom) : '0;
      if (off == 1) d = 8'($urandom_range(0, 11));
      if (off == 4 && $urandom_range(0, 3) == 0) d = 8'h80;
      if (off == 9 && $urandom_range(0, 3) != 0) off = 8;
      sel = (k < 90);
      w   = (k % 2) == 0;
      r   = !w;
      if (k >= 95) begin w = 0; r = 0; end
      cyc(sel, w, r, off, bc, d, hits);
    end

    // Asynchronous reset in the middle of a multi-byte staging write
    wr(1, 0, 8'h01);
    for (int b = 0; b < 4; b++) wr(2, b, 8'(8'h30 + b));
    wr(4, 0, 8'h00);
    for (int i = 0; i < 5; i++) idle(8'h02);
    reg_addrvalid = 1; reg_address = 8'hC2; reg_bytecnt = 7'd4;
    write_data = 8'hA5; reg_write = 1; reg_read = 0; I_match_hit = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_patterns", 512'(O_trace_patterns), 512'(0));
    chk("async_masks", 512'(O_trace_masks), {512{1'b1}});
    chk("async_pen", 512'(O_pattern_enable), 512'(0));
    chk("async_read_data", 512'(read_data), 512'(0));
    model_reset();
    reg_write = 0; reg_addrvalid = 0;
    @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    rd_lit("post_rst_stage", 2, 0, 8'h00);
    rd_lit("post_rst_smask", 3, 4, 8'hFF);
    rd_lit("post_rst_index", 1, 0, 8'h00);
    wr(1, 0, 8'h02);
    rd_lit("post_rst_hit", 8, 0, 8'h00);
    idle('0);

    cmp_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_trace_rules.md
# reg_trace_rules

Parametrised match-rule register bank for the trace trigger, generalising the fixed 8-rule trace register set to any rule count and pattern width. Rules are programmed through an indexed staging window and committed atomically, so the trigger never sees a half-written pattern/mask pair. Per-rule saturating hit counters are read back through a tear-free snapshot. Sits beside the existing trace register block on the cw305_usb_reg_fe bus and drives trace_trigger directly.

## Interface
Parameters:
- pBYTECNT_SIZE, 7, width of reg_bytecnt
- pBUFFER_SIZE, 64, pattern/mask width in bits; multiple of 8, 8..128
- pMATCH_RULES, 8, number of rules, 1..16
- pSELECT, 2'b11, value of reg_address[7:6] that selects this block
- pCOUNT_WIDTH, 16, hit counter width, 8 or 16

Ports:
- usb_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- reg_address  in  8  register address; [5:0] is offset
- reg_bytecnt  in  pBYTECNT_SIZE  byte index within register
- write_data  in  8  write byte
- read_data  out  8  read byte, registered
- reg_read  in  1  read strobe
- reg_write  in  1  write strobe
- reg_addrvalid  in  1  address valid
- selected  out  1  reg_addrvalid & (reg_address[7:6] == pSELECT)
- I_match_hit  in  pMATCH_RULES  one-cycle hit pulses from trace_trigger, synchronous to usb_clk
- O_trace_patterns  out  pMATCH_RULES*pBUFFER_SIZE  rule r at [r*pBUFFER_SIZE +: pBUFFER_SIZE]
- O_trace_masks  out  pMATCH_RULES*pBUFFER_SIZE  same packing
- O_pattern_enable  out  pMATCH_RULES  per-rule match enable
- O_pattern_trig_enable  out  pMATCH_RULES  per-rule trigger enable
- O_commit  out  1  one-cycle pulse on successful commit

## Operation
Offsets (reg_address[5:0]); all accesses gated by selected:
- 0x00 INFO (RO): byte0 = pMATCH_RULES, byte1 = pBUFFER_SIZE/8, byte2 = pCOUNT_WIDTH.
- 0x01 RULE_INDEX (RW): 4-bit rule index; stores write_data[3:0] unconditionally.
- 0x02 STAGE_PATTERN / 0x03 STAGE_MASK (RW): staging registers, byte reg_bytecnt.
- 0x04 RULE_COMMIT: any write copies staging into rule[RULE_INDEX] and pulses O_commit. If RULE_INDEX >= pMATCH_RULES: no copy, no pulse, sets sticky error. Read: bit0 = error. A write of 0x80 clears error without committing.
- 0x05 RULE_LOAD (W): copies rule[RULE_INDEX] into staging; out-of-range index loads pattern 0, mask all ones.
- 0x06 PATTERN_ENABLE / 0x07 TRIG_ENABLE (RW): byte-addressed bit vectors; bits >= pMATCH_RULES read 0, writes to them are dropped.
- 0x08 HIT_COUNT (RO): reading byte 0 latches counter[RULE_INDEX] into a snapshot and returns its low byte; bytes >0 return from snapshot.
- 0x09 CLEAR_COUNTS (W): zeroes all counters.
- Byte indices beyond a register's width: writes ignored, reads 0. Unmapped offsets read 0.
- Counters: +1 per I_match_hit pulse, saturate at all ones. CLEAR_COUNTS coincident with a hit wins (counter = 0).
- Commit coincident with a staging write: commit uses pre-write staging value; staging update still lands.

## Timing
- Reset values: patterns 0; masks all ones; staging pattern 0, mask all ones; enables 0; RULE_INDEX 0; counters and snapshot 0; error 0; O_commit 0; read_data 0.
- reset_n assertion clears all state immediately, including mid-commit or mid-readout; deassertion synchronous to usb_clk edge.
- Writes take effect on the usb_clk edge where reg_write is high; outputs update that edge.
- read_data valid one cycle after reg_read (combinational mux plus one register). Snapshot latched on the same edge as byte-0 read_data.
- O_commit high exactly one cycle, cycle after commit write edge coincides with new O_trace_* values.

## Configuration
- TRACE_HIT_COUNTERS_EN: defined: counters, snapshot, HIT_COUNT, CLEAR_COUNTS implemented as above. Undefined: no counter logic; HIT_COUNT reads 0, CLEAR_COUNTS is a no-op, INFO byte2 reads 0, I_match_hit ignored.

## Test plan
- Reset, read INFO with defaults -> bytes 0x08, 0x08, 0x10; read O_trace_masks -> all ones; PATTERN_ENABLE -> 0x00.
- INDEX=3, stage pattern 0x1122334455667788, mask 0xFF00FF00FF00FF00, commit -> O_commit one cycle, rule 3 slice updated in same cycle, rules 0-2 and 4-7 unchanged.
- INDEX=9 (pMATCH_RULES=8), commit -> no O_commit, RULE_COMMIT reads 0x01; write 0x80 -> reads 0x00.
- Pulse I_match_hit[2] 70000 times with pCOUNT_WIDTH=16 -> HIT_COUNT rule 2 reads 0xFFFF; CLEAR_COUNTS coincident with hit -> reads 0x0000.
- Read HIT_COUNT byte 0 at count 0x00FF, inject 1 hit, read byte 1 -> 0x00 (snapshot, not 0x01).
- Assert reset_n low mid-way through multi-byte staging write -> staging, rules, counters return to reset values asynchronously.
